// File: rtl/ray_config_bank_if.sv
// Memory bus between a master and the ray-tracer configuration bank.
// ms_* carries requests to the slave; sm_* returns read responses.
interface ray_config_bank_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 24,
  parameter int unsigned IdWidth   = 4
);
  logic [AddrWidth-1:0] ms_address;
  logic [DataWidth-1:0] ms_data;
  logic                 ms_write;
  logic [IdWidth-1:0]   ms_id;
  logic                 ms_valid;
  logic                 ms_taken;
  logic [DataWidth-1:0] sm_data;
  logic [IdWidth-1:0]   sm_id;
  logic                 sm_valid;
  logic                 sm_taken;

  modport master (
    output ms_address, ms_data, ms_write, ms_id, ms_valid, sm_taken,
    input  ms_taken, sm_data, sm_id, sm_valid
  );

  modport slave (
    input  ms_address, ms_data, ms_write, ms_id, ms_valid, sm_taken,
    output ms_taken, sm_data, sm_id, sm_valid
  );
endinterface

// File: rtl/ray_config_bank.sv
// Control/status register bank for NumCores ray-tracer cores: shadowed camera/frame settings
// committed on START, sticky done interrupts and a two-entry read-response FIFO.
module ray_config_bank #(
  parameter int unsigned NumCores      = 2,
  parameter int unsigned PositionWidth = 16,
  parameter int unsigned DataWidth     = 24,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned Address       = 0,
  parameter int unsigned BaseWidth     = 8,
  parameter int unsigned IdWidth       = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  output logic [AddressWidth-1:0]                     material_address_o,
  output logic [AddressWidth-1:0]                     tree_address_o,
  output logic [NumCores-1:0][AddressWidth-1:0]       frame_address_o,
  output logic [NumCores-1:0][2:0][PositionWidth-1:0] camera_q_o,
  output logic [NumCores-1:0][2:0][PositionWidth-1:0] camera_v_o,
  output logic [NumCores-1:0][2:0][PositionWidth-1:0] camera_x_o,
  output logic [NumCores-1:0][2:0][PositionWidth-1:0] camera_y_o,
  output logic [NumCores-1:0][11:0]                   width_o,
  output logic [NumCores-1:0][11:0]                   height_o,
  output logic [NumCores-1:0]                         normalize_o,
  output logic [NumCores-1:0]                         start_o,
  input  logic [NumCores-1:0]                         ready_i,
  input  logic [NumCores-1:0]                         busy_i,
  output logic [NumCores-1:0]                         flush_o,
  output logic [NumCores-1:0]                         reset_rt_o,
  output logic                                        interrupt_o,
  ray_config_bank_if.slave                            bus
);
  localparam int unsigned PageWidth = BaseWidth - 5;
  localparam int unsigned HiWidth   = AddressWidth - 8;
  localparam int unsigned TagWidth  = AddressWidth - BaseWidth;
  localparam logic [TagWidth-1:0] BlockTag = TagWidth'(Address);

  typedef struct packed {
    logic                            norm;
    logic [11:0][PositionWidth-1:0]  cam;
    logic [11:0]                     width;
    logic [11:0]                     height;
    logic [HiWidth-1:0]              frame;
  } core_cfg_t;

  core_cfg_t shadow_q [NumCores];
  core_cfg_t shadow_d [NumCores];
  core_cfg_t active_q [NumCores];
  core_cfg_t active_d [NumCores];

  logic [HiWidth-1:0]  material_q, material_d, tree_q, tree_d;
  logic [NumCores-1:0] irq_q, irq_d, mask_q, mask_d, pending_q, pending_d, last_busy_q;
  logic [NumCores-1:0] start_q, flush_q, reset_rt_q;
  logic [NumCores-1:0] start_req, launch, flush_wr, rt_wr, irq_clr;
  logic                interrupt_q;

  logic [DataWidth-1:0] fifo_data_q [2];
  logic [IdWidth-1:0]   fifo_id_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;

  logic [PageWidth-1:0] page;
  logic [4:0]           reg_sel;
  logic [3:0]           cam_idx;
  logic                 sel, wr_acc, rd_acc, pop;
  logic [DataWidth-1:0] rdata;

  assign page    = bus.ms_address[BaseWidth-1:5];
  assign reg_sel = bus.ms_address[4:0];
  assign cam_idx = 4'(reg_sel - 5'd1);
  assign sel     = bus.ms_valid && (bus.ms_address[AddressWidth-1:BaseWidth] == BlockTag);
  assign pop     = bus.sm_valid && bus.sm_taken;
  assign wr_acc  = sel && bus.ms_write;
  // A full FIFO can still accept a read when its head is leaving this cycle.
  assign rd_acc  = sel && !bus.ms_write && (count_q != 2'd2 || pop);

  assign bus.ms_taken = wr_acc || rd_acc;
  assign bus.sm_valid = (count_q != 2'd0);
  assign bus.sm_data  = fifo_data_q[rd_ptr_q];
  assign bus.sm_id    = fifo_id_q[rd_ptr_q];

  always_comb begin
    rdata = '0;
    if (page == '0) begin
      case (reg_sel)
        5'h0:    rdata = DataWidth'({ready_i, busy_i});
        5'h1:    rdata = DataWidth'(irq_q);
        5'h2:    rdata = DataWidth'(mask_q);
        5'h3:    rdata = DataWidth'(material_q);
        5'h4:    rdata = DataWidth'(tree_q);
        5'h6:    rdata = DataWidth'(pending_q);
        default: rdata = '0;
      endcase
    end
    for (int k = 0; k < NumCores; k++) begin
      if (page == PageWidth'(k + 1)) begin
        if (reg_sel == 5'h0)                         rdata = DataWidth'(shadow_q[k].norm);
        else if (reg_sel <= 5'hC)                    rdata = DataWidth'(shadow_q[k].cam[cam_idx]);
        else if (reg_sel == 5'hD)                    rdata = DataWidth'(shadow_q[k].width);
        else if (reg_sel == 5'hE)                    rdata = DataWidth'(shadow_q[k].height);
        else if (reg_sel == 5'hF)                    rdata = DataWidth'(shadow_q[k].frame);
      end
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    material_d = material_q;
    tree_d     = tree_q;
    mask_d     = mask_q;
    start_req  = '0;
    flush_wr   = '0;
    rt_wr      = '0;
    irq_clr    = '0;
    if (wr_acc) begin
      if (page == '0) begin
        case (reg_sel)
          5'h1:    irq_clr    = bus.ms_data[NumCores-1:0];
          5'h2:    mask_d     = bus.ms_data[NumCores-1:0];
          5'h3:    material_d = HiWidth'(bus.ms_data);
          5'h4:    tree_d     = HiWidth'(bus.ms_data);
          5'h5:    start_req  = bus.ms_data[NumCores-1:0];
          default: ;
        endcase
      end
      for (int k = 0; k < NumCores; k++) begin
        if (page == PageWidth'(k + 1)) begin
          if (reg_sel == 5'h0) begin
            shadow_d[k].norm = bus.ms_data[0];
            flush_wr[k]      = bus.ms_data[1];
            rt_wr[k]         = bus.ms_data[2];
          end else if (reg_sel <= 5'hC) begin
            shadow_d[k].cam[cam_idx] = PositionWidth'(bus.ms_data);
          end else if (reg_sel == 5'hD) begin
            shadow_d[k].width = bus.ms_data[11:0];
          end else if (reg_sel == 5'hE) begin
            shadow_d[k].height = bus.ms_data[11:0];
          end else if (reg_sel == 5'hF) begin
            shadow_d[k].frame = HiWidth'(bus.ms_data);
          end
        end
      end
    end
    // A new done event wins over a simultaneous W1C of the same bit.
    irq_d     = (irq_q & ~irq_clr) | (last_busy_q & ~busy_i);
    launch    = (pending_q | start_req) & ~busy_i & ready_i & ~rt_wr;
    pending_d = (pending_q | start_req) & ~launch & ~rt_wr;
    for (int k = 0; k < NumCores; k++) begin
      active_d[k] = launch[k] ? shadow_q[k] : active_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumCores; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      material_q  <= '0;
      tree_q      <= '0;
      irq_q       <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      last_busy_q <= '0;
      start_q     <= '0;
      flush_q     <= '0;
      reset_rt_q  <= '0;
      interrupt_q <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_id_q[0]   <= '0;
      fifo_id_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      material_q  <= material_d;
      tree_q      <= tree_d;
      irq_q       <= irq_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      last_busy_q <= busy_i;
      start_q     <= launch;
      flush_q     <= flush_wr;
      reset_rt_q  <= rt_wr;
      interrupt_q <= |(irq_q & mask_q);
      if (rd_acc) begin
        fifo_data_q[wr_ptr_q] <= rdata;
        fifo_id_q[wr_ptr_q]   <= bus.ms_id;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, rd_acc} - {1'b0, pop};
    end
  end

  always_comb begin
    for (int k = 0; k < NumCores; k++) begin
      frame_address_o[k] = {active_q[k].frame, 8'h00};
      for (int i = 0; i < 3; i++) begin
        camera_q_o[k][i] = active_q[k].cam[i];
        camera_v_o[k][i] = active_q[k].cam[i + 3];
        camera_x_o[k][i] = active_q[k].cam[i + 6];
        camera_y_o[k][i] = active_q[k].cam[i + 9];
      end
      width_o[k]     = active_q[k].width;
      height_o[k]    = active_q[k].height;
      normalize_o[k] = active_q[k].norm;
    end
  end

  assign material_address_o = {material_q, 8'h00};
  assign tree_address_o     = {tree_q, 8'h00};
  assign start_o            = start_q;
  assign flush_o            = flush_q;
  assign reset_rt_o         = reset_rt_q | {NumCores{~rst_ni}};
  assign interrupt_o        = interrupt_q;
endmodule

// File: tb/tb_ray_config_bank.sv
// Directed bench for ray_config_bank: commit/launch, done interrupts, FIFO back-pressure,
// W1C races, unmapped accesses, resetRT and asynchronous reset.
module tb_ray_config_bank;
  localparam int unsigned NC = 2;
  localparam int unsigned PW = 16;
  localparam int unsigned DW = 24;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]                  ready, busy;
  logic [AW-1:0]                  material_address, tree_address;
  logic [NC-1:0][AW-1:0]          frame_address;
  logic [NC-1:0][2:0][PW-1:0]     camera_q, camera_v, camera_x, camera_y;
  logic [NC-1:0][11:0]            width, height;
  logic [NC-1:0]                  normalize, start, flush, reset_rt;
  logic                           interrupt;

  ray_config_bank_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

  ray_config_bank #(
    .NumCores(NC), .PositionWidth(PW), .DataWidth(DW), .AddressWidth(AW),
    .Address(0), .BaseWidth(8), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .material_address_o(material_address), .tree_address_o(tree_address),
    .frame_address_o(frame_address),
    .camera_q_o(camera_q), .camera_v_o(camera_v), .camera_x_o(camera_x), .camera_y_o(camera_y),
    .width_o(width), .height_o(height), .normalize_o(normalize), .start_o(start),
    .ready_i(ready), .busy_i(busy), .flush_o(flush), .reset_rt_o(reset_rt),
    .interrupt_o(interrupt), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] offs(input int page, input int r);
    return AW'((page << 5) | r);
  endfunction

  task automatic wr(input int page, input int r, input logic [DW-1:0] d);
    bus.ms_valid = 1'b1; bus.ms_write = 1'b1;
    bus.ms_address = offs(page, r); bus.ms_data = d;
    @(posedge clk); #1;
    bus.ms_valid = 1'b0; bus.ms_write = 1'b0;
  endtask

  task automatic rd(input int page, input int r, output logic [DW-1:0] d);
    int n;
    bus.sm_taken = 1'b1; bus.ms_valid = 1'b1; bus.ms_write = 1'b0;
    bus.ms_address = offs(page, r); bus.ms_id = 4'hA;
    @(posedge clk); #1;
    bus.ms_valid = 1'b0;
    n = 0;
    while (!bus.sm_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.sm_valid) begin
      checks++; errors++;
      $error("FAIL read_timeout: observed=no response expected=response");
      d = 'x;
    end else begin
      d = bus.sm_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_check(input string tag, input int page, input int r, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    rd(page, r, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready = '0; busy = '0;
    bus.ms_valid = 1'b0; bus.ms_write = 1'b0; bus.ms_address = '0;
    bus.ms_data = '0; bus.ms_id = '0; bus.sm_taken = 1'b0;

    #12;
    check("rst_reset_rt", 64'(reset_rt), 64'h3);
    check("rst_start", 64'(start), 64'h0);
    check("rst_sm_valid", 64'(bus.sm_valid), 64'h0);
    check("rst_interrupt", 64'(interrupt), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rt_release", 64'(reset_rt), 64'h0);

    // Immediate commit on idle, ready core 0.
    ready = 2'b11;
    wr(1, 1, 24'h1234);
    check("shadow_not_active", 64'(camera_q[0][0]), 64'h0);
    wr(0, 5, 24'h1);
    check("start0_pulse", 64'(start), 64'h1);
    check("q0_committed", 64'(camera_q[0][0]), 64'h1234);
    @(posedge clk); #1;
    check("start0_one_cycle", 64'(start), 64'h0);

    // Deferred commit on busy core 1.
    busy = 2'b10;
    @(posedge clk); #1;
    wr(2, 'hD, 24'd640);
    wr(0, 2, 24'h2);
    wr(0, 5, 24'h2);
    check("width1_held", 64'(width[1]), 64'h0);
    check("no_start_busy", 64'(start), 64'h0);
    rd_check("pending_busy", 0, 6, 24'h2);
    busy = 2'b00;
    @(posedge clk); #1;
    check("start1_pulse", 64'(start), 64'h2);
    check("width1_committed", 64'(width[1]), 64'd640);
    check("irq_latency", 64'(interrupt), 64'h0);
    @(posedge clk); #1;
    check("irq_asserted", 64'(interrupt), 64'h1);
    rd_check("irq_status", 0, 1, 24'h2);
    wr(2, 'hD, 24'd100);
    check("active_hold", 64'(width[1]), 64'd640);
    rd_check("shadow_readback", 2, 'hD, 24'd100);
    wr(0, 1, 24'h2);
    @(posedge clk); #1;
    check("irq_cleared", 64'(interrupt), 64'h0);
    rd_check("irq_status_clr", 0, 1, 24'h0);

    // Read FIFO back-pressure and ordering.
    bus.sm_taken = 1'b0;
    bus.ms_valid = 1'b1; bus.ms_write = 1'b0; bus.ms_address = offs(0, 2); bus.ms_id = 4'd1;
    #1 check("fifo_acc1", 64'(bus.ms_taken), 64'h1);
    @(posedge clk); #1;
    bus.ms_address = offs(0, 6); bus.ms_id = 4'd2;
    #1 check("fifo_acc2", 64'(bus.ms_taken), 64'h1);
    @(posedge clk); #1;
    bus.ms_address = offs(2, 'hD); bus.ms_id = 4'd3;
    #1 check("fifo_stall", 64'(bus.ms_taken), 64'h0);
    check("fifo_valid", 64'(bus.sm_valid), 64'h1);
    @(posedge clk); #1;
    #1 check("fifo_stall_hold", 64'(bus.ms_taken), 64'h0);
    bus.sm_taken = 1'b1;
    #1 check("fifo_pop_push", 64'(bus.ms_taken), 64'h1);
    check("fifo_id1", 64'(bus.sm_id), 64'd1);
    check("fifo_data1", 64'(bus.sm_data), 64'h2);
    @(posedge clk); #1;
    bus.ms_valid = 1'b0;
    check("fifo_id2", 64'(bus.sm_id), 64'd2);
    @(posedge clk); #1;
    check("fifo_id3", 64'(bus.sm_id), 64'd3);
    check("fifo_data3", 64'(bus.sm_data), 64'd100);
    @(posedge clk); #1;
    check("fifo_empty", 64'(bus.sm_valid), 64'h0);

    // Done event beats a simultaneous W1C.
    busy = 2'b01;
    @(posedge clk); #1;
    busy = 2'b00;
    wr(0, 1, 24'h1);
    rd_check("w1c_race", 0, 1, 24'h1);
    wr(0, 1, 24'h1);
    rd_check("w1c_clear", 0, 1, 24'h0);

    busy = 2'b10;
    rd_check("status", 0, 0, 24'hE);
    busy = 2'b00;
    rd_check("unmapped_p7", 7, 'h1F, 24'h0);
    rd_check("unmapped_p3", 3, 1, 24'h0);
    rd_check("cam_readback", 1, 1, 24'h1234);

    // resetRT cancels a pending commit.
    busy = 2'b01;
    @(posedge clk); #1;
    wr(0, 5, 24'h1);
    rd_check("pending0", 0, 6, 24'h1);
    wr(1, 0, 24'h4);
    check("reset_rt_pulse", 64'(reset_rt), 64'h1);
    check("no_flush", 64'(flush), 64'h0);
    @(posedge clk); #1;
    check("reset_rt_end", 64'(reset_rt), 64'h0);
    rd_check("pending0_clr", 0, 6, 24'h0);
    busy = 2'b00;
    @(posedge clk); #1;
    check("no_start_after_rt_a", 64'(start), 64'h0);
    @(posedge clk); #1;
    check("no_start_after_rt_b", 64'(start), 64'h0);

    wr(2, 0, 24'h3);
    check("flush1_pulse", 64'(flush), 64'h2);
    check("norm1_active", 64'(normalize[1]), 64'h0);
    rd_check("ctrl1_readback", 2, 0, 24'h1);
    wr(0, 3, 24'hABCDEF);
    check("material", 64'(material_address), 64'hABCDEF00);
    wr(0, 4, 24'h12);
    check("tree", 64'(tree_address), 64'h1200);

    // Asynchronous reset in the middle of a pending commit.
    busy = 2'b10;
    @(posedge clk); #1;
    wr(2, 1, 24'h55);
    wr(0, 5, 24'h2);
    rst_n = 1'b0;
    #1;
    check("arst_width", 64'(width[1]), 64'h0);
    check("arst_reset_rt", 64'(reset_rt), 64'h3);
    check("arst_material", 64'(material_address), 64'h0);
    check("arst_q0", 64'(camera_q[0][0]), 64'h0);
    busy = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_no_start", 64'(start), 64'h0);
    end
    rd_check("arst_pending", 0, 6, 24'h0);
    check("arst_cam1", 64'(camera_q[1][0]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
